seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_iter.sv | 88 ++++++++
 rtl/seq_alu.sv | 119 +++++++++++
 tb/tb_seq_alu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and op classification.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpSll  = 4'd5,
        OpSrl  = 4'd6,
        OpSra  = 4'd7,
        OpSlt  = 4'd8,
        OpSltu = 4'd9,
        OpMul  = 4'd10,
        OpDivu = 4'd11,
        OpRemu = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } alu_state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OpMul) || (op == OpDivu) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative shift-add multiplier and restoring divider, one operand bit per cycle.
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_op1,
    input  logic [DATA_WIDTH-1:0] i_op2,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int unsigned DW = DATA_WIDTH;

    // MUL: r_x = shifted multiplicand, r_y = multiplier, r_acc = product.
    // DIV: r_x = dividend shifting out / quotient shifting in, r_y = divisor, r_acc = remainder.
    logic            r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]      r_op;
    logic [DW-1:0]   r_x;
    logic [DW-1:0]   r_y;
    logic [DW-1:0]   r_acc;

    logic [DW-1:0]   w_x_next;
    logic [DW-1:0]   w_y_next;
    logic [DW-1:0]   w_acc_next;
    logic [DW:0]     w_shift;
    logic            w_qbit;

    always_comb begin
        w_shift    = {r_acc, r_x[DW-1]};
        w_qbit     = (w_shift >= {1'b0, r_y});
        w_x_next   = r_x;
        w_y_next   = r_y;
        w_acc_next = r_acc;
        if (r_op == OpMul) begin
            w_acc_next = r_acc + (r_y[0] ? r_x : '0);
            w_x_next   = r_x << 1;
            w_y_next   = r_y >> 1;
        end else begin
            // Divide by zero falls out naturally: every bit subtracts, remainder ends as op1.
            w_acc_next = w_qbit ? (w_shift[DW-1:0] - r_y) : w_shift[DW-1:0];
            w_x_next   = {r_x[DW-2:0], w_qbit};
        end
    end

    // The final step's value is forwarded so the caller can register it on the done edge.
    assign o_done = r_active && (r_cnt == CNT_W'(DW - 1));

    always_comb begin
        o_result = w_acc_next;
        if (r_op == OpDivu) begin
            o_result = w_x_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_op     <= 4'd0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_op     <= i_op;
            r_x      <= i_op1;
            r_y      <= i_op2;
            r_acc    <= '0;
        end else if (r_active) begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops registered straight into result, MUL/DIVU/REMU via alu_iter.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  eq,
    output logic                  busy
);

    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    alu_state_t            r_state;
    alu_state_t            w_state_next;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] w_result_next;
    logic                  r_eq;
    logic                  w_eq_next;
    logic [DATA_WIDTH-1:0] w_simple;
    logic [SHW-1:0]        w_shamt;
    logic                  w_iter_start;
    logic                  w_iter_done;
    logic [DATA_WIDTH-1:0] w_iter_result;

    always_comb begin
        w_shamt  = op2[SHW-1:0];
        w_simple = '0;
        case (op)
            OpAdd:   w_simple = op1 + op2;
            OpSub:   w_simple = op1 - op2;
            OpAnd:   w_simple = op1 & op2;
            OpOr:    w_simple = op1 | op2;
            OpXor:   w_simple = op1 ^ op2;
            OpSll:   w_simple = op1 << w_shamt;
            OpSrl:   w_simple = op1 >> w_shamt;
            OpSra:   w_simple = DATA_WIDTH'($signed(op1) >>> w_shamt);
            OpSlt:   w_simple = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OpSltu:  w_simple = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
            default: w_simple = '0;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_eq_next     = r_eq;
        w_iter_start  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_eq_next = (op1 == op2);
                    if (is_iter_op(op)) begin
                        w_iter_start = 1'b1;
                        w_state_next = StCalc;
                    end else begin
                        w_result_next = w_simple;
                        w_state_next  = StDone;
                    end
                end
            end
            StCalc: begin
                if (w_iter_done) begin
                    w_result_next = w_iter_result;
                    w_state_next  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_eq     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_result <= w_result_next;
            r_eq     <= w_eq_next;
        end
    end

    alu_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_iter_start),
        .i_op     (op),
        .i_op1    (op1),
        .i_op2    (op2),
        .o_done   (w_iter_done),
        .o_result (w_iter_result)
    );

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state == StCalc);
    assign result    = r_result;
    assign eq        = r_eq;

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus randomized checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [DW-1:0] op1 = '0;
    logic [DW-1:0] op2 = '0;
    logic          in_ready;
    logic          out_valid;
    logic          eq;
    logic          busy;
    logic [DW-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .eq        (eq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [3:0] o, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        int unsigned sh;
        sh = b % DW;
        case (o)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpSll:   return a << sh;
            OpSrl:   return a >> sh;
            OpSra:   return DW'($signed(a) >>> sh);
            OpSlt:   return ($signed(a) < $signed(b)) ? 1 : 0;
            OpSltu:  return (a < b) ? 1 : 0;
            OpMul:   return a * b;
            OpDivu:  return (b == 0) ? '1 : a / b;
            OpRemu:  return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic logic is_long(input logic [3:0] o);
        return (o == OpMul) || (o == OpDivu) || (o == OpRemu);
    endfunction

    // Present at a falling edge, count rising edges until out_valid, stall, then consume.
    task automatic run_op(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int stall);
        logic [DW-1:0] exp;
        int            lat;
        int            want;
        exp  = model(o, a, b);
        want = is_long(o) ? DW + 1 : 1;
        chk("ready_before_accept", in_ready, 1);
        op = o; op1 = a; op2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        chk("busy_after_accept", busy, is_long(o));
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency_op%0d", o), lat, want);
        chk($sformatf("result_op%0d", o), result, exp);
        chk("eq", eq, a == b);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            op  = 4'($urandom_range(0, 15));
            op1 = $urandom;
            op2 = $urandom;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, exp);
            chk("hold_eq", eq, a == b);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consumed_valid", out_valid, 0);
        chk("consumed_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [3:0]    r_o;
        logic [DW-1:0] r_a;
        logic [DW-1:0] r_b;
        int            seen;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_eq", eq, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OpAdd,  32'hFFFF_FFFF, 32'h1, 0);
        run_op(OpSra,  32'h8000_0000, 32'h24, 0);
        run_op(OpSlt,  32'hFFFF_FFFF, 32'h1, 0);
        run_op(OpSltu, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(OpMul,  32'h0001_0001, 32'h0001_0001, 0);
        run_op(OpDivu, 32'd100, 32'd7, 0);
        run_op(OpRemu, 32'd100, 32'd7, 0);
        run_op(OpDivu, 32'd5, 32'd0, 0);
        run_op(OpRemu, 32'd5, 32'd0, 0);
        run_op(OpXor,  32'h1234_5678, 32'h1234_5678, 5);
        run_op(OpSub,  32'h0, 32'h1, 0);
        run_op(4'd13,  32'hDEAD_BEEF, 32'h1, 0);
        run_op(OpDivu, 32'hFFFF_FFFF, 32'd3, 3);

        // Reset ten cycles into a multiply: nothing may emerge afterwards.
        op = OpMul; op1 = 32'h0000_0003; op2 = 32'h0000_0005; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_calc_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("no_result_after_abort", seen, 0);
        chk("ready_after_abort", in_ready, 1);

        for (int i = 0; i < 40; i++) begin
            r_o = 4'($urandom_range(0, 15));
            r_a = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = r_a;
                1:       r_b = '0;
                2:       r_b = $urandom_range(0, 40);
                default: r_b = $urandom;
            endcase
            run_op(r_o, r_a, r_b, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
